// File: rtl/pokey_arb_pkg.sv
// Shared constants and FSM encoding for the POKEY register-access arbiter.
package pokey_arb_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_AUX = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } arb_state_e;

endpackage

// File: rtl/pokey_strobe_decode.sv
// Address to one-hot strobe decoder; all-zero when not enabled.
module pokey_strobe_decode
  import pokey_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                     en,
  input  logic [ADDR_W-1:0]        addr,
  output logic [(2**ADDR_W)-1:0]   strobe
);

  // One-hot decode of the address, gated by enable
  always_comb begin
    strobe = '0;
    if (en) begin
      strobe[addr] = 1'b1;
    end else begin
      strobe = '0;
    end
  end

endmodule

// File: rtl/pokey_reg_arbiter.sv
// Two-requester register-file arbiter: IDLE -> ACCESS (one strobe) -> ACK.
// Optional POKEY_ARB_ROUND_ROBIN_EN alternates grants on ties; otherwise requester 0 wins.
module pokey_reg_arbiter
  import pokey_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    req0,
  input  logic                    req1,
  input  logic                    we0,
  input  logic                    we1,
  input  logic [ADDR_W-1:0]       addr0,
  input  logic [ADDR_W-1:0]       addr1,
  input  logic [DATA_W-1:0]       wdata0,
  input  logic [DATA_W-1:0]       wdata1,
  output logic                    ack0,
  output logic                    ack1,
  output logic [DATA_W-1:0]       rdata0,
  output logic [DATA_W-1:0]       rdata1,
  output logic [(2**ADDR_W)-1:0]  wr_strobe,
  output logic [(2**ADDR_W)-1:0]  rd_strobe,
  output logic [DATA_W-1:0]       reg_wdata,
  input  logic [DATA_W-1:0]       reg_rdata,
  output logic                    busy
);

  localparam int NREG = 2**ADDR_W;

  arb_state_e          state_r, state_nxt_s;
  logic                gnt_r, we_r;
  logic                gnt_sel_s, grant_s;
  logic                sel_we_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic [NREG-1:0]     wr_dec_s, rd_dec_s;
  logic [NREG-1:0]     wr_strobe_r, rd_strobe_r;
  logic                ack0_nxt_s, ack1_nxt_s, cap0_s, cap1_s;
  logic                ack0_r, ack1_r, busy_r;
  logic [DATA_W-1:0]   rdata0_r, rdata1_r, reg_wdata_r;

`ifdef POKEY_ARB_ROUND_ROBIN_EN
  logic last_gnt_r;

  // Requester selection: on a tie, favour whoever was not granted last
  always_comb begin
    gnt_sel_s = REQ_AUX;
    if (req0 && req1) begin
      gnt_sel_s = ~last_gnt_r;
    end else if (req0) begin
      gnt_sel_s = REQ_CPU;
    end else begin
      gnt_sel_s = REQ_AUX;
    end
  end

  // Last-grant history, starting as if requester 1 had just been served
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      last_gnt_r <= REQ_AUX;
    end else if (grant_s) begin
      last_gnt_r <= gnt_sel_s;
    end else begin
      last_gnt_r <= last_gnt_r;
    end
  end
`else
  // Requester selection: fixed priority to the CPU port
  always_comb begin
    gnt_sel_s = REQ_AUX;
    if (req0) begin
      gnt_sel_s = REQ_CPU;
    end else begin
      gnt_sel_s = REQ_AUX;
    end
  end
`endif

  assign grant_s     = (state_r == ST_IDLE) && (req0 || req1);
  assign sel_we_s    = (gnt_sel_s == REQ_AUX) ? we1    : we0;
  assign sel_addr_s  = (gnt_sel_s == REQ_AUX) ? addr1  : addr0;
  assign sel_wdata_s = (gnt_sel_s == REQ_AUX) ? wdata1 : wdata0;

  // Strobes are decoded at grant and registered so they appear for the ACCESS cycle only
  pokey_strobe_decode #(.ADDR_W(ADDR_W)) u_wr_dec (
    .en     (grant_s && sel_we_s),
    .addr   (sel_addr_s),
    .strobe (wr_dec_s)
  );

  pokey_strobe_decode #(.ADDR_W(ADDR_W)) u_rd_dec (
    .en     (grant_s && !sel_we_s),
    .addr   (sel_addr_s),
    .strobe (rd_dec_s)
  );

  // FSM state register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:   state_nxt_s = grant_s ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: state_nxt_s = ST_ACK;
      ST_ACK:    state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values for the registered acks and read-data capture
  always_comb begin
    ack0_nxt_s = 1'b0;
    ack1_nxt_s = 1'b0;
    cap0_s     = 1'b0;
    cap1_s     = 1'b0;
    if (state_r == ST_ACCESS) begin
      ack0_nxt_s = (gnt_r == REQ_CPU);
      ack1_nxt_s = (gnt_r == REQ_AUX);
      cap0_s     = (gnt_r == REQ_CPU) && !we_r;
      cap1_s     = (gnt_r == REQ_AUX) && !we_r;
    end else begin
      ack0_nxt_s = 1'b0;
      ack1_nxt_s = 1'b0;
    end
  end

  // Transaction fields latched at grant
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      gnt_r       <= REQ_CPU;
      we_r        <= 1'b0;
      reg_wdata_r <= '0;
    end else if (grant_s) begin
      gnt_r       <= gnt_sel_s;
      we_r        <= sel_we_s;
      reg_wdata_r <= sel_wdata_s;
    end else begin
      gnt_r       <= gnt_r;
      we_r        <= we_r;
      reg_wdata_r <= reg_wdata_r;
    end
  end

  // Registered outputs; rdata of the other port and on writes simply holds
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_strobe_r <= '0;
      rd_strobe_r <= '0;
      ack0_r      <= 1'b0;
      ack1_r      <= 1'b0;
      busy_r      <= 1'b0;
      rdata0_r    <= '0;
      rdata1_r    <= '0;
    end else begin
      wr_strobe_r <= wr_dec_s;
      rd_strobe_r <= rd_dec_s;
      ack0_r      <= ack0_nxt_s;
      ack1_r      <= ack1_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
      rdata0_r    <= cap0_s ? reg_rdata : rdata0_r;
      rdata1_r    <= cap1_s ? reg_rdata : rdata1_r;
    end
  end

  assign wr_strobe = wr_strobe_r;
  assign rd_strobe = rd_strobe_r;
  assign ack0      = ack0_r;
  assign ack1      = ack1_r;
  assign busy      = busy_r;
  assign rdata0    = rdata0_r;
  assign rdata1    = rdata1_r;
  assign reg_wdata = reg_wdata_r;

endmodule

// File: tb/tb_pokey_reg_arbiter.sv
// Directed and random-traffic bench for pokey_reg_arbiter (honours POKEY_ARB_ROUND_ROBIN_EN).
module tb_pokey_reg_arbiter;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        req0, req1, we0, we1;
  logic [3:0]  addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        ack0, ack1;
  logic [7:0]  rdata0, rdata1;
  logic [15:0] wr_strobe, rd_strobe;
  logic [7:0]  reg_wdata, reg_rdata;
  logic        busy;

  logic        use_model;
  logic [7:0]  rd_fixed;
  logic [7:0]  model_s;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pokey_reg_arbiter dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .wr_strobe(wr_strobe), .rd_strobe(rd_strobe),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .busy(busy)
  );

  function automatic logic [7:0] model_rd(input logic [3:0] a);
    return {a, ~a};
  endfunction

  // Register-file stand-in: value depends on the strobed address
  always_comb begin
    model_s = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (rd_strobe[i]) model_s = model_rd(4'(i));
    end
  end
  assign reg_rdata = use_model ? model_s : rd_fixed;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 4'h0; addr1 = 4'h0; wdata0 = 8'h00; wdata1 = 8'h00;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
  endtask

  int          ack_ids[$];
  int          ack_cyc[$];
  int          stray;
  int          bad;
  int          n_str, n_ack;
  logic        pend0, pend1, prev_valid, prev_wr, owner, exp_we;
  logic [15:0] prev_str, str_any;
  logic [3:0]  exp_addr;

  initial begin
    use_model = 1'b0;
    rd_fixed  = 8'h00;
    idle_inputs();
    RESET_N = 1'b0;
    tick();
    check_val("rst_ack", {ack1, ack0}, 2'b00);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_strobes", {wr_strobe, rd_strobe}, 32'h0);
    check_val("rst_rdata", {rdata1, rdata0}, 16'h0000);
    check_val("rst_wdata", reg_wdata, 8'h00);
    RESET_N = 1'b1;

    // Write to register 3
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'h3; wdata0 = 8'hA5;
    tick();
    check_val("wr_strobe", wr_strobe, 16'h0008);
    check_val("wr_rd_zero", rd_strobe, 16'h0000);
    check_val("wr_wdata", reg_wdata, 8'hA5);
    check_val("wr_busy1", busy, 1'b1);
    tick();
    req0 = 1'b0;
    check_val("wr_ack", {ack1, ack0}, 2'b01);
    check_val("wr_strobe_off", wr_strobe, 16'h0000);
    tick();
    check_val("wr_busy_end", busy, 1'b0);
    check_val("wr_ack_end", ack0, 1'b0);
    check_val("wr_rdata_hold", rdata0, 8'h00);

    // Read from register 15 on the aux port
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'hF; rd_fixed = 8'h5C;
    tick();
    check_val("rd_strobe", rd_strobe, 16'h8000);
    check_val("rd_wr_zero", wr_strobe, 16'h0000);
    tick();
    req1 = 1'b0;
    check_val("rd_ack", {ack1, ack0}, 2'b10);
    check_val("rd_rdata1", rdata1, 8'h5C);
    check_val("rd_rdata0_hold", rdata0, 8'h00);
    tick();
    check_val("rd_ack_end", ack1, 1'b0);

    // Tie: both requests held from reset release
    RESET_N = 1'b0;
    idle_inputs();
    tick();
    req0 = 1'b1; addr0 = 4'h1; req1 = 1'b1; addr1 = 4'h2;
    RESET_N = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ack0) begin ack_ids.push_back(0); ack_cyc.push_back(i); end
      if (ack1) begin ack_ids.push_back(1); ack_cyc.push_back(i); end
    end
    idle_inputs();
    check_val("tie_count", ack_ids.size(), 4);
    for (int k = 0; k < 4 && k < ack_ids.size(); k++) begin
`ifdef POKEY_ARB_ROUND_ROBIN_EN
      check_val($sformatf("tie_id%0d", k), ack_ids[k], k % 2);
`else
      check_val($sformatf("tie_id%0d", k), ack_ids[k], 0);
`endif
      check_val($sformatf("tie_cyc%0d", k), ack_cyc[k], 1 + 3 * k);
    end
    tick(); tick(); tick();

    // Fields latched at grant; dropping req does not cancel
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'h2; wdata0 = 8'h11;
    tick();
    addr0 = 4'h7; wdata0 = 8'hEE; req0 = 1'b0;
    check_val("lat_strobe", wr_strobe, 16'h0004);
    tick();
    check_val("lat_ack", ack0, 1'b1);
    check_val("lat_wdata", reg_wdata, 8'h11);
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ack0 || ack1 || wr_strobe != 16'h0 || rd_strobe != 16'h0 || busy) stray++;
    end
    check_val("lat_no_regrant", stray, 0);

    // Reset during ACCESS aborts the transaction
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'h1; wdata0 = 8'h3C;
    tick();
    check_val("rst_mid_strobe", wr_strobe, 16'h0002);
    RESET_N = 1'b0;
    #1;
    check_val("rst_mid_clear", {wr_strobe, rd_strobe, 14'h0, ack1, ack0}, 48'h0);
    check_val("rst_mid_busy", busy, 1'b0);
    req0 = 1'b0;
    tick();
    RESET_N = 1'b1;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ack0 || ack1 || wr_strobe != 16'h0 || rd_strobe != 16'h0) stray++;
    end
    check_val("rst_no_ack", stray, 0);
    RESET_N = 1'b0;
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'h5; rd_fixed = 8'h77;
    RESET_N = 1'b1;
    tick();
    check_val("rst_first_grant", rd_strobe, 16'h0020);
    req0 = 1'b0;
    tick();
    check_val("rst_first_ack", ack0, 1'b1);
    check_val("rst_first_rdata", rdata0, 8'h77);
    tick();

    // Random traffic with per-cycle exclusivity and ack/grant matching
    do_reset();
    use_model = 1'b1;
    pend0 = 1'b0; pend1 = 1'b0; prev_valid = 1'b0; prev_wr = 1'b0; prev_str = 16'h0;
    bad = 0; n_str = 0; n_ack = 0;
    for (int cyc = 0; cyc < 10006; cyc++) begin
      tick();
      str_any = wr_strobe | rd_strobe;
      if ($countones(str_any) > 1) bad++;
      if (wr_strobe != 16'h0 && rd_strobe != 16'h0) bad++;
      if (prev_valid) begin
        if ((ack0 ^ ack1) != 1'b1) begin
          bad++;
        end else begin
          owner    = ack1;
          exp_addr = owner ? addr1 : addr0;
          exp_we   = owner ? we1 : we0;
          if (!(owner ? pend1 : pend0)) bad++;
          if (prev_str != (16'h0001 << exp_addr)) bad++;
          if (prev_wr != exp_we) bad++;
          if (!exp_we && (owner ? rdata1 : rdata0) != model_rd(exp_addr)) bad++;
          n_ack++;
        end
      end else if (ack0 || ack1) begin
        bad++;
      end
      prev_valid = (str_any != 16'h0);
      prev_str   = str_any;
      prev_wr    = (wr_strobe != 16'h0);
      if (prev_valid) n_str++;
      if (ack0) pend0 = 1'b0;
      if (ack1) pend1 = 1'b0;
      if (!pend0) begin
        if (cyc < 10000 && $urandom_range(0, 2) == 0) begin
          pend0 = 1'b1; req0 = 1'b1; we0 = 1'($urandom);
          addr0 = 4'($urandom); wdata0 = 8'($urandom);
        end else begin
          req0 = 1'b0;
        end
      end
      if (!pend1) begin
        if (cyc < 10000 && $urandom_range(0, 2) == 0) begin
          pend1 = 1'b1; req1 = 1'b1; we1 = 1'($urandom);
          addr1 = 4'($urandom); wdata1 = 8'($urandom);
        end else begin
          req1 = 1'b0;
        end
      end
    end
    check_val("rnd_violations", bad, 0);
    check_val("rnd_str_eq_ack", n_str, n_ack);
    check_val("rnd_activity", (n_ack > 1000), 1'b1);
    check_val("rnd_drained", {pend1, pend0, busy}, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
